// File: rtl/e_mult_div_unit_pkg.sv
// Shared encodings and defaults for the EX-stage multiply/divide unit.
package md_defs;

    localparam int MD_WIDTH       = 32;
    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    function automatic logic is_start(input logic [2:0] op);
        return op == MD_MULT || op == MD_MULTU ||
               op == MD_DIV  || op == MD_DIVU;
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return op == MD_DIV || op == MD_DIVU;
    endfunction

endpackage

// File: rtl/e_mult_div_unit_datapath.sv
// Combinational product / quotient-remainder generator.
// Result is {hi, lo}; hold flags a divide by zero.
module md_datapath
    import md_defs::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic [2*WIDTH-1:0] result,
    output logic               hold
);

    localparam int W2 = 2 * WIDTH;

    logic          sgn;
    logic          div_zero;
    logic [W2-1:0] ext_a;
    logic [W2-1:0] ext_b;
    logic [W2-1:0] safe_b;
    logic [W2-1:0] prod;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    assign sgn = op == MD_MULT || op == MD_DIV;

    assign ext_a = sgn ? {{WIDTH{src_a[WIDTH-1]}}, src_a}
                       : {{WIDTH{1'b0}}, src_a};
    assign ext_b = sgn ? {{WIDTH{src_b[WIDTH-1]}}, src_b}
                       : {{WIDTH{1'b0}}, src_b};

    assign div_zero = src_b == '0;
    assign hold     = is_div(op) && div_zero;

    // Keep the divider away from zero; the result is discarded anyway.
    assign safe_b = div_zero ? W2'(1) : ext_b;

    // With proper extension the low 2W bits are right for both signednesses.
    assign prod = ext_a * ext_b;

    assign quo = sgn ? WIDTH'($signed(ext_a) / $signed(safe_b))
                     : WIDTH'(ext_a / safe_b);
    assign rem = sgn ? WIDTH'($signed(ext_a) % $signed(safe_b))
                     : WIDTH'(ext_a % safe_b);

    always_comb begin
        result = '0;
        unique case (1'b1)
            op == MD_MULT,
            op == MD_MULTU: result = prod;
            is_div(op):     result = {rem, quo};
            default:        result = '0;
        endcase
    end

endmodule

// File: rtl/e_mult_div_unit.sv
// EX-stage mult/div unit with HI/LO pair and fixed-latency busy window.
// HL_busy stalls md/mt/mf instructions held in ID.
module e_mult_div_unit
    import md_defs::*;
#(
    parameter int WIDTH       = MD_WIDTH,
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hl_sel,
    output logic [WIDTH-1:0] hl_rdata,
    output logic             busy,
    output logic             HL_busy,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES
                                                     : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    md_state_e        state;
    md_state_e        state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] pend_hi;
    logic [WIDTH-1:0] pend_lo;
    logic             pend_hold;
    logic             start;
    logic             done;
    logic [2*WIDTH-1:0] dp_result;
    logic             dp_hold;

    md_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .op     (md_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .result (dp_result),
        .hold   (dp_hold)
    );

    assign start = is_start(md_op) && state == IDLE;
    assign done  = state == BUSY && cnt == CW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            state == IDLE && start: state_nxt = BUSY;
            done:                   state_nxt = IDLE;
            default:                state_nxt = state;
        endcase
    end

    always_comb begin
        busy    = state == BUSY;
        HL_busy = start || busy;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_hold <= 1'b0;
        end else if (start) begin
            cnt       <= is_div(md_op) ? CW'(DIV_CYCLES)
                                       : CW'(MULT_CYCLES);
            pend_hi   <= dp_result[2*WIDTH-1:WIDTH];
            pend_lo   <= dp_result[WIDTH-1:0];
            pend_hold <= dp_hold;
        end else if (busy) begin
            cnt <= cnt - CW'(1);
        end
    end

    // mt writes only land while idle; the hazard unit keeps them out of BUSY.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (done) begin
            if (!pend_hold) begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
            end
        end else if (state == IDLE) begin
            if (md_op == MD_MTHI) hi_q <= src_a;
            if (md_op == MD_MTLO) lo_q <= src_a;
        end
    end

    assign hl_rdata = hl_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_e_mult_div_unit.sv
// Directed bench for e_mult_div_unit: latency, results, mt/mf, reset abort.
module tb_e_mult_div_unit;
    import md_defs::*;

    logic        clk;
    logic        reset_n;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hl_sel;
    logic [31:0] hl_rdata;
    logic        busy;
    logic        HL_busy;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    int n_tot;
    int n_pass;
    int illegal;

    e_mult_div_unit dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .md_op    (md_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .hl_sel   (hl_sel),
        .hl_rdata (hl_rdata),
        .busy     (busy),
        .HL_busy  (HL_busy),
        .hi_q     (hi_q),
        .lo_q     (lo_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts md/mt issues that reach the unit while it is busy.
    always @(posedge clk) begin
        if (reset_n && busy && md_op != MD_NONE && md_op != 3'd7)
            illegal <= illegal + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic [31:0] ehi,
                          input logic [31:0] elo);
        int cnt;
        @(negedge clk);
        md_op = op;
        src_a = a;
        src_b = b;
        #1;
        chk({tag, " HL_busy issue"}, 64'(HL_busy), 64'd1);
        chk({tag, " busy issue"}, 64'(busy), 64'd0);
        @(negedge clk);
        md_op = MD_NONE;
        wait_idle(cnt);
        chk({tag, " busy cycles"}, 64'(cnt), 64'(n));
        chk({tag, " hi"}, 64'(hi_q), 64'(ehi));
        chk({tag, " lo"}, 64'(lo_q), 64'(elo));
    endtask

    task automatic mt(input logic [2:0] op, input logic [31:0] v);
        @(negedge clk);
        md_op = op;
        src_a = v;
        @(negedge clk);
        md_op = MD_NONE;
        chk("mt busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int cnt;
        n_tot   = 0;
        n_pass  = 0;
        illegal = 0;
        reset_n = 1'b0;
        md_op   = MD_NONE;
        src_a   = '0;
        src_b   = '0;
        hl_sel  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst hi", 64'(hi_q), 64'd0);
        chk("rst lo", 64'(lo_q), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst HL_busy", 64'(HL_busy), 64'd0);
        reset_n = 1'b1;

        hl_sel = 1'b1;
        mt(MD_MTHI, 32'hDEADBEEF);
        chk("mthi rdata", 64'(hl_rdata), 64'hDEADBEEF);
        mt(MD_MTLO, 32'h0BADF00D);
        hl_sel = 1'b0;
        #1;
        chk("mtlo rdata", 64'(hl_rdata), 64'h0BADF00D);

        run_op("mult", MD_MULT, 32'hFFFFFFFD, 32'd5, 5,
               32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("multu", MD_MULTU, 32'hFFFFFFFF, 32'd2, 5,
               32'h00000001, 32'hFFFFFFFE);
        run_op("div", MD_DIV, 32'hFFFFFFF9, 32'd2, 10,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu", MD_DIVU, 32'hFFFFFFF9, 32'd2, 10,
               32'h00000001, 32'h7FFFFFFC);
        run_op("div ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 10,
               32'h00000000, 32'h80000000);
        chk("HL_busy idle", 64'(HL_busy), 64'd0);

        mt(MD_MTHI, 32'h11111111);
        mt(MD_MTLO, 32'h22222222);
        run_op("divu0", MD_DIVU, 32'h12345678, 32'd0, 10,
               32'h11111111, 32'h22222222);
        run_op("div0", MD_DIV, 32'h87654321, 32'd0, 10,
               32'h11111111, 32'h22222222);
        chk("illegal none", 64'(illegal), 64'd0);

        // mthi arriving during a mult must be dropped
        @(negedge clk);
        md_op = MD_MULT;
        src_a = 32'd3;
        src_b = 32'd4;
        @(negedge clk);
        md_op = MD_MTHI;
        src_a = 32'hABCD0123;
        @(negedge clk);
        md_op = MD_NONE;
        chk("mthi busy ignored", 64'(hi_q), 64'h11111111);
        wait_idle(cnt);
        chk("mult2 cycles", 64'(cnt + 1), 64'd5);
        chk("mult2 hi", 64'(hi_q), 64'd0);
        chk("mult2 lo", 64'(lo_q), 64'd12);
        chk("illegal flagged", 64'(illegal), 64'd1);

        // reset during a div at T+4
        @(negedge clk);
        md_op = MD_DIV;
        src_a = 32'd100;
        src_b = 32'd7;
        @(negedge clk);
        md_op = MD_NONE;
        repeat (3) @(negedge clk);
        chk("abort busy pre", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort hi", 64'(hi_q), 64'd0);
        chk("abort lo", 64'(lo_q), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("abort no commit hi", 64'(hi_q), 64'd0);
        chk("abort no commit lo", 64'(lo_q), 64'd0);
        chk("abort idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/e_mult_div_unit.md
Name: e_mult_div_unit

Overview:
- Multiply/divide unit and HI/LO register pair in the EX stage of the P6 five-stage MIPS pipeline.
- Executes mult/multu/div/divu with a fixed multi-cycle latency, and mthi/mtlo in a single cycle.
- Returns HI or LO for mfhi/mflo.
- Drives HL_busy into the hazard controller, which stalls any md/mt/mf instruction in ID while the unit is occupied.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- md_op  input  3  operation for the instruction in EX; encoding in package; MD_NONE when no md/mt instruction
- src_a  input  WIDTH  forwarded rs value
- src_b  input  WIDTH  forwarded rt value
- hl_sel  input  1  read select: 0 = LO (mflo), 1 = HI (mfhi)
- hl_rdata  output  WIDTH  hl_sel ? HI : LO, combinational
- busy  output  1  registered; high while an operation is in flight
- HL_busy  output  1  start | busy, fed to the hazard controller
- hi_q  output  WIDTH  HI register, for debug
- lo_q  output  WIDTH  LO register, for debug

Behaviour:
- Reset (reset_n low, asynchronous):
  - HI = 0, LO = 0, busy = 0, counter = 0, pending result registers = 0, state = IDLE.
  - Reset mid-operation abandons the operation; HI/LO read 0.
- start = (md_op is MULT/MULTU/DIV/DIVU) and state == IDLE.
- States are IDLE and BUSY. A cycle counter is sized ceil(log2(max(MULT_CYCLES, DIV_CYCLES) + 1)) bits.
- IDLE to BUSY on the edge after start (op in EX at cycle T):
  - counter is loaded with MULT_CYCLES or DIV_CYCLES;
  - result is computed into pend_hi and pend_lo.
- Result rules:
  - mult: signed 64-bit product; HI = product[63:32], LO = product[31:0].
  - multu: unsigned 64-bit product, same split.
  - div: LO = signed quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero: the full latency still elapses, but HI and LO stay unchanged when the op completes (no commit).
- BUSY: counter decrements every edge. On the edge where counter goes 1 to 0, pend_hi/pend_lo are committed to HI/LO and the state returns to IDLE.
- Timing:
  - busy is high for exactly N cycles (T+1 … T+N).
  - The new HI/LO are visible from cycle T+N+1.
  - HL_busy is high for cycles T … T+N.
- mthi / mtlo:
  - When IDLE, HI (or LO) = src_a on the next edge; busy stays 0.
  - When BUSY, the write is ignored. The hazard controller guarantees this case never occurs; the bench flags it with an assertion.
- A start request while BUSY is ignored, with the same assertion. The in-flight operation is unaffected.
- hl_rdata reflects the committed HI/LO only. Pending results are never visible.
- The md/mt/mf stall comes solely from HL_busy. The unit has no flush input in P6.
- All arithmetic is done at 2*WIDTH. Operands are sign-extended for signed ops and zero-extended for unsigned ops.

Decomposition:
- Package md_defs:
  - md_op encoding: MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6 (7 reserved, treated as NONE);
  - state encoding: IDLE=0, BUSY=1;
  - default latency constants.
- One natural sub-module, md_datapath: a purely combinational block producing the 64-bit {hi, lo} result from op, src_a and src_b, including the div-by-zero hold flag.
- FSM, counter and HI/LO registers stay in e_mult_div_unit.

Test Plan:
- mult with src_a = 0xFFFFFFFD (−3) and src_b = 5 -> busy high for 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; HL_busy high in the issue cycle.
- multu with src_a = 0xFFFFFFFF and src_b = 2 -> after 5 cycles HI = 0x00000001, LO = 0xFFFFFFFE.
- div with src_a = 0xFFFFFFF9 (−7) and src_b = 2 -> busy high for 10 cycles, then LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). Repeat as divu: LO = 0x7FFFFFFC, HI = 0x00000001.
- divu by zero with HI/LO preloaded to 0x11111111/0x22222222 -> busy high for 10 cycles, then HI/LO unchanged.
- mthi 0xDEADBEEF, then hl_sel = 1 -> hl_rdata = 0xDEADBEEF on the next cycle, with busy never asserted. Then mult issued with mthi attempted while busy -> write ignored and assertion fires.
- div issued, reset_n pulsed low at cycle T+4 -> busy, HI and LO go to 0 immediately (asynchronously), and no commit occurs afterwards.
